// File: rtl/rotor_stage.sv
// ============================================================================
//  Module   : rotor_stage
//  Brief    : Clocked Enigma rotor stage with programmable wiring, ring,
//             stepping, notch carry and optional double-step.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module rotor_stage #(
    parameter int                   ALPHA       = 26,
    parameter int                   W           = 5,
    parameter logic [ALPHA*W-1:0]   WIRING      = {5'd9,  5'd2,  5'd17, 5'd1,  5'd8,  5'd0,
                                                   5'd15, 5'd18, 5'd20, 5'd23, 5'd7,  5'd24,
                                                   5'd22, 5'd14, 5'd19, 5'd13, 5'd25, 5'd21,
                                                   5'd16, 5'd3,  5'd6,  5'd11, 5'd5,  5'd12,
                                                   5'd10, 5'd4},
    parameter int                   NOTCH       = 16,
    parameter bit                   DOUBLE_STEP = 1'b0
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         load,
    input  logic [W-1:0] load_pos,
    input  logic [W-1:0] load_ring,
    input  logic         step_req,
    input  logic         step_in,
    input  logic         in_valid,
    input  logic         in_dir,
    input  logic [W-1:0] in_letter,
    output logic         out_valid,
    output logic [W-1:0] out_letter,
    output logic         out_err,
    output logic [W-1:0] pos,
    output logic         at_notch,
    output logic         carry_out
);

    localparam logic [W:0]   c_alpha = (W+1)'(ALPHA);
    localparam logic [W-1:0] c_notch = W'(NOTCH);

    function automatic logic [ALPHA*W-1:0] f_invert(input logic [ALPHA*W-1:0] wiring);
        logic [ALPHA*W-1:0] inv;
        inv = '0;
        for (int i = 0; i < ALPHA; i++) begin
            inv[int'(wiring[i*W +: W])*W +: W] = W'(i);
        end
        return inv;
    endfunction

    localparam logic [ALPHA*W-1:0] c_inv = f_invert(WIRING);

    // Operands are always < ALPHA, so a single conditional subtract suffices.
    function automatic logic [W-1:0] f_mod_add(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] t;
        t = {1'b0, a} + {1'b0, b};
        if (t >= c_alpha) t = t - c_alpha;
        return t[W-1:0];
    endfunction

    function automatic logic [W-1:0] f_mod_sub(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] t;
        t = {1'b0, a} + c_alpha - {1'b0, b};
        if (t >= c_alpha) t = t - c_alpha;
        return t[W-1:0];
    endfunction

    logic [W-1:0] r_pos;
    logic [W-1:0] r_ring;
    logic         r_out_valid;
    logic [W-1:0] r_out_letter;
    logic         r_out_err;

    logic         w_at_notch;
    logic         w_step;
    logic         w_in_err;
    logic [W-1:0] w_letter;
    logic [W-1:0] w_s;
    logic [W-1:0] w_w;
    logic [W-1:0] w_result;
    logic [W-1:0] w_load_pos;
    logic [W-1:0] w_load_ring;

    assign w_at_notch  = (r_pos == c_notch);
    assign w_step      = step_in | (DOUBLE_STEP & step_req & w_at_notch);
    assign w_in_err    = ({1'b0, in_letter} >= c_alpha);
    assign w_load_pos  = ({1'b0, load_pos}  >= c_alpha) ? '0 : load_pos;
    assign w_load_ring = ({1'b0, load_ring} >= c_alpha) ? '0 : load_ring;

    // Out-of-range letters are forced to 0 so the wiring lookup stays in range.
    assign w_letter = w_in_err ? '0 : in_letter;

    always_comb begin
        w_s      = f_mod_sub(f_mod_add(w_letter, r_pos), r_ring);
        w_w      = in_dir ? c_inv[int'(w_s)*W +: W] : WIRING[int'(w_s)*W +: W];
        w_result = f_mod_sub(f_mod_add(w_w, r_ring), r_pos);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_pos        <= '0;
            r_ring       <= '0;
            r_out_valid  <= 1'b0;
            r_out_letter <= '0;
            r_out_err    <= 1'b0;
        end else begin
            if (load) begin
                r_pos  <= w_load_pos;
                r_ring <= w_load_ring;
            end else if (w_step) begin
                r_pos  <= f_mod_add(r_pos, W'(1));
            end
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_out_letter <= w_in_err ? in_letter : w_result;
                r_out_err    <= w_in_err;
            end
        end
    end

    assign out_valid  = r_out_valid;
    assign out_letter = r_out_letter;
    assign out_err    = r_out_err;
    assign pos        = r_pos;
    assign at_notch   = w_at_notch;
    assign carry_out  = resetn & w_step & w_at_notch & ~load;

endmodule

`default_nettype wire

// File: tb/tb_rotor_stage.sv
// ============================================================================
//  Module   : tb_rotor_stage
//  Brief    : Self-checking bench for rotor_stage (rotor I, notch Q).
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_rotor_stage;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       load = 1'b0;
    logic [4:0] load_pos = '0;
    logic [4:0] load_ring = '0;
    logic       step_req = 1'b0;
    logic       step_in = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_dir = 1'b0;
    logic [4:0] in_letter = '0;

    logic       out_valid, out_err, at_notch, carry_out;
    logic [4:0] out_letter, pos;
    logic       out_valid_ds, out_err_ds, at_notch_ds, carry_out_ds;
    logic [4:0] out_letter_ds, pos_ds;

    rotor_stage #(.DOUBLE_STEP(1'b0)) dut (
        .clk(clk), .resetn(resetn), .load(load), .load_pos(load_pos), .load_ring(load_ring),
        .step_req(step_req), .step_in(step_in), .in_valid(in_valid), .in_dir(in_dir),
        .in_letter(in_letter), .out_valid(out_valid), .out_letter(out_letter),
        .out_err(out_err), .pos(pos), .at_notch(at_notch), .carry_out(carry_out)
    );

    rotor_stage #(.DOUBLE_STEP(1'b1)) dut_ds (
        .clk(clk), .resetn(resetn), .load(load), .load_pos(load_pos), .load_ring(load_ring),
        .step_req(step_req), .step_in(step_in), .in_valid(in_valid), .in_dir(in_dir),
        .in_letter(in_letter), .out_valid(out_valid_ds), .out_letter(out_letter_ds),
        .out_err(out_err_ds), .pos(pos_ds), .at_notch(at_notch_ds), .carry_out(carry_out_ds)
    );

    always #5 clk = ~clk;

    int    n_cmp  = 0;
    int    n_fail = 0;
    string c_rotor = "EKMFLGDQVZNTOWYHXUSPAIBRCJ";
    int    wmap[26];

    typedef struct {
        int lpos;
        int lring;
        bit dir;
        int letter;
        int exp_letter;
        bit exp_err;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int md(input int v);
        return ((v % 26) + 26) % 26;
    endfunction

    // Reference cipher: direct table lookup / linear inverse search.
    function automatic int ref_cipher(input int l, input bit dir, input int p, input int r);
        int s, w;
        if (l >= 26) return l;
        s = md(l + p - r);
        w = 0;
        if (!dir) w = wmap[s];
        else for (int j = 0; j < 26; j++) if (wmap[j] == s) w = j;
        return md(w - p + r);
    endfunction

    task automatic do_load(input int lp, input int lr);
        load = 1'b1; load_pos = 5'(lp); load_ring = 5'(lr);
        tick();
        load = 1'b0;
    endtask

    initial begin
        int m_pos, m_ring, m_pos_ds;
        int exp_l, exp_l_ds;
        bit exp_e, have;

        for (int i = 0; i < 26; i++) wmap[i] = int'(c_rotor[i]) - 65;

        vecs[0] = '{0,  0, 1'b0, 0,  4,  1'b0};
        vecs[1] = '{0,  0, 1'b1, 4,  0,  1'b0};
        vecs[2] = '{1,  0, 1'b0, 0,  9,  1'b0};
        vecs[3] = '{0,  1, 1'b0, 0,  10, 1'b0};
        vecs[4] = '{0,  0, 1'b0, 28, 28, 1'b1};
        vecs[5] = '{25, 0, 1'b0, 0,  10, 1'b0};
        vecs[6] = '{5,  3, 1'b1, 7,  23, 1'b0};
        vecs[7] = '{30, 0, 1'b0, 0,  4,  1'b0};

        // Reset state
        #2;
        chk("rst_pos", pos, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_letter", out_letter, 0);
        chk("rst_out_err", out_err, 0);
        step_in = 1'b1;
        #1;
        chk("rst_carry", carry_out, 0);
        step_in = 1'b0;
        #10 resetn = 1'b1;
        tick();

        // Table-driven encipherment
        for (int i = 0; i < 8; i++) begin
            do_load(vecs[i].lpos, vecs[i].lring);
            in_valid = 1'b1; in_dir = vecs[i].dir; in_letter = 5'(vecs[i].letter);
            tick();
            in_valid = 1'b0;
            chk($sformatf("vec%0d_valid", i), out_valid, 1);
            chk($sformatf("vec%0d_letter", i), out_letter, vecs[i].exp_letter);
            chk($sformatf("vec%0d_err", i), out_err, vecs[i].exp_err);
        end
        chk("load_oor_pos", pos, 0);
        tick();
        chk("hold_valid", out_valid, 0);
        chk("hold_letter", out_letter, 4);

        // Step and wrap
        do_load(24, 0);
        step_in = 1'b1;
        tick();
        chk("wrap_pos25", pos, 25);
        tick();
        chk("wrap_pos0", pos, 0);
        step_in = 1'b0;

        // Notch carry and load priority over step
        do_load(16, 0);
        chk("notch_at", at_notch, 1);
        step_in = 1'b1; #1;
        chk("notch_carry", carry_out, 1);
        tick();
        chk("notch_pos17", pos, 17);
        step_in = 1'b0;
        do_load(15, 0);
        step_in = 1'b1; #1;
        chk("prenotch_carry", carry_out, 0);
        step_in = 1'b0;
        do_load(16, 0);
        load = 1'b1; load_pos = 5'd7; step_in = 1'b1; #1;
        chk("loadstep_carry", carry_out, 0);
        tick();
        load = 1'b0; step_in = 1'b0;
        chk("loadstep_pos", pos, 7);

        // Double step
        do_load(16, 0);
        step_req = 1'b1; #1;
        chk("ds_carry", carry_out_ds, 1);
        chk("nods_carry", carry_out, 0);
        tick();
        step_req = 1'b0;
        chk("ds_pos", pos_ds, 17);
        chk("nods_pos", pos, 16);

        // Asynchronous reset mid-stream
        do_load(3, 0);
        in_valid = 1'b1; in_dir = 1'b0; in_letter = 5'd0;
        tick();
        in_valid = 1'b0;
        chk("mid_valid", out_valid, 1);
        chk("mid_letter", out_letter, 2);
        #1 resetn = 1'b0;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_pos", pos, 0);
        chk("arst_letter", out_letter, 0);
        resetn = 1'b1;
        tick();
        in_valid = 1'b1; in_dir = 1'b0; in_letter = 5'd0;
        tick();
        in_valid = 1'b0;
        chk("post_rst_letter", out_letter, 4);

        // Randomised traffic against the reference model
        m_pos = $urandom_range(0, 25); m_ring = $urandom_range(0, 25); m_pos_ds = m_pos;
        do_load(m_pos, m_ring);
        have = 1'b0; exp_l = 0; exp_l_ds = 0; exp_e = 1'b0;
        for (int n = 0; n < 400; n++) begin
            bit dl, si, sr, iv, dr, st_ds;
            int lp, lr, lt;
            dl = ($urandom_range(0, 9) == 0);
            lp = $urandom_range(0, 31); lr = $urandom_range(0, 31);
            si = 1'($urandom_range(0, 1)); sr = 1'($urandom_range(0, 1));
            iv = ($urandom_range(0, 3) != 0); dr = 1'($urandom_range(0, 1));
            lt = ($urandom_range(0, 15) == 0) ? $urandom_range(26, 31) : $urandom_range(0, 25);
            load = dl; load_pos = 5'(lp); load_ring = 5'(lr);
            step_in = si; step_req = sr; in_valid = iv; in_dir = dr; in_letter = 5'(lt);
            #1;
            st_ds = si | (sr && m_pos_ds == 16);
            chk("rnd_carry", carry_out, 32'(si && m_pos == 16 && !dl));
            chk("rnd_carry_ds", carry_out_ds, 32'(st_ds && m_pos_ds == 16 && !dl));
            if (iv) begin
                exp_l    = ref_cipher(lt, dr, m_pos, m_ring);
                exp_l_ds = ref_cipher(lt, dr, m_pos_ds, m_ring);
                exp_e    = (lt >= 26);
                have     = 1'b1;
            end
            tick();
            if (dl) begin
                m_pos = (lp >= 26) ? 0 : lp;
                m_ring = (lr >= 26) ? 0 : lr;
                m_pos_ds = m_pos;
            end else begin
                if (si) m_pos = md(m_pos + 1);
                if (st_ds) m_pos_ds = md(m_pos_ds + 1);
            end
            chk("rnd_valid", out_valid, 32'(iv));
            chk("rnd_pos", pos, m_pos);
            chk("rnd_pos_ds", pos_ds, m_pos_ds);
            if (have) begin
                chk("rnd_letter", out_letter, exp_l);
                chk("rnd_err", out_err, 32'(exp_e));
                chk("rnd_letter_ds", out_letter_ds, exp_l_ds);
            end
        end
        load = 1'b0; step_in = 1'b0; step_req = 1'b0; in_valid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
